// File: rtl/rs232_uart_rx.sv
// rtl/rs232_uart_rx.sv - 8N1 RS-232 receiver with single-entry valid/ready byte output
module rs232_uart_rx #(
  parameter int CLKS_PER_BIT = 1042
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_TC = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [2:0]      idx, idx_nx;
  logic [7:0]      shreg;
  logic            rx_meta, rx_s;
  logic            sample_bit;
  logic            frame_ok;
  logic            frame_bad;

  // Two-flop synchronizer; the line idles high so reset to 1 avoids a false start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // State, bit-time counter and bit index registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
    end
  end

  // Next-state logic: half-bit start check, then mid-bit sampling of data and stop.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    idx_nx     = idx;
    sample_bit = 1'b0;
    frame_ok   = 1'b0;
    frame_bad  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          state_nx = S_START;
          cnt_nx   = '0;
        end
      end
      S_START: begin
        if (cnt == HALF_TC) begin
          cnt_nx   = '0;
          idx_nx   = '0;
          state_nx = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt == FULL_TC) begin
          sample_bit = 1'b1;
          cnt_nx     = '0;
          if (idx == 3'd7) begin
            state_nx = S_STOP;
          end else begin
            idx_nx = idx + 1'b1;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt == FULL_TC) begin
          cnt_nx = '0;
          if (rx_s) begin
            frame_ok = 1'b1;
            state_nx = S_IDLE;
          end else begin
            frame_bad = 1'b1;
            state_nx  = S_BREAK;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_BREAK: begin
        if (rx_s) begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Data bits land LSB first at the current bit index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg <= '0;
    end else if (sample_bit) begin
      shreg[idx] <= rx_s;
    end
  end

  // Holding register: accept a good byte if empty or draining this cycle, else flag overrun.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= frame_bad;
      overrun   <= 1'b0;
      if (frame_ok && (!data_valid || data_ready)) begin
        data_out   <= shreg;
        data_valid <= 1'b1;
      end else begin
        if (frame_ok) begin
          overrun <= 1'b1;
        end
        if (data_valid && data_ready) begin
          data_valid <= 1'b0;
        end
      end
    end
  end

  // Busy reflects any activity beyond waiting for a start edge.
  always_comb begin
    busy = (state != S_IDLE);
  end

endmodule

// File: tb/tb_rs232_uart_rx.sv
// tb/tb_rs232_uart_rx.sv - self-checking bench for rs232_uart_rx
module tb_rs232_uart_rx;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       data_ready;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  int         cyc = 0;
  logic [7:0] got [0:1023];
  int         got_n    = 0;
  int         ferr_n   = 0;
  int         ovr_n    = 0;
  int         vhi_n    = 0;
  int         rise_cyc = 0;
  logic       dv_prev  = 1'b0;
  int         fall_cyc = 0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_n;
    int         exp_ferr;
  } vec_t;

  vec_t vecs [6];

  rs232_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (data_valid && data_ready) begin
        got[got_n] <= data_out;
        got_n      <= got_n + 1;
      end
      if (frame_err) ferr_n <= ferr_n + 1;
      if (overrun) ovr_n <= ovr_n + 1;
      if (data_valid) vhi_n <= vhi_n + 1;
      if (data_valid && !dv_prev) rise_cyc <= cyc;
    end
    dv_prev <= data_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input logic stop);
    fall_cyc = cyc;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bits(b, stop);
    rx = 1'b1;
  endtask

  initial begin
    int g0, f0, o0, v0;
    int exp_ferr;
    logic [7:0] exp_q [$];
    logic [7:0] b;
    logic ok;

    vecs[0] = '{8'h00, 1'b1, 1, 0};
    vecs[1] = '{8'hFF, 1'b1, 1, 0};
    vecs[2] = '{8'h80, 1'b1, 1, 0};
    vecs[3] = '{8'h01, 1'b1, 1, 0};
    vecs[4] = '{8'hA5, 1'b0, 0, 1};
    vecs[5] = '{8'h5A, 1'b1, 1, 0};

    // Reset
    rst_n = 1'b0;
    rx = 1'b1;
    data_ready = 1'b0;
    tick(3);
    @(negedge clk);
    check("reset data_out", data_out, 8'h00);
    check("reset data_valid", data_valid, 1'b0);
    check("reset frame_err", frame_err, 1'b0);
    check("reset overrun", overrun, 1'b0);
    check("reset busy", busy, 1'b0);
    tick(1);
    rst_n = 1'b1;
    tick(4);
    send_frame(8'h55, 1'b1);
    tick(2);
    check("0x55 latency", rise_cyc - fall_cyc, 79);
    @(negedge clk);
    check("0x55 data_out", data_out, 8'h55);
    check("0x55 data_valid", data_valid, 1'b1);
    tick(1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset clears valid", data_valid, 1'b0);
    check("reset clears data_out", data_out, 8'h00);
    tick(4);

    // Table-driven single frames
    data_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      g0 = got_n;
      f0 = ferr_n;
      send_frame(vecs[i].data, vecs[i].stop);
      tick(20);
      check($sformatf("vec%0d count", i), got_n - g0, vecs[i].exp_n);
      if (vecs[i].exp_n > 0) check($sformatf("vec%0d byte", i), got[g0], vecs[i].data);
      check($sformatf("vec%0d frame_err", i), ferr_n - f0, vecs[i].exp_ferr);
    end

    // Handshake and back-to-back
    g0 = got_n; f0 = ferr_n; o0 = ovr_n; v0 = vhi_n;
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    tick(10);
    check("b2b count", got_n - g0, 2);
    check("b2b first", got[g0], 8'hA3);
    check("b2b second", got[g0+1], 8'h0F);
    check("b2b valid cycles", vhi_n - v0, 2);
    check("b2b frame_err", ferr_n - f0, 0);
    check("b2b overrun", ovr_n - o0, 0);

    // Overrun
    data_ready = 1'b0;
    g0 = got_n; o0 = ovr_n;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(10);
    @(negedge clk);
    check("ovr data_valid held", data_valid, 1'b1);
    check("ovr data_out kept", data_out, 8'h11);
    check("ovr pulses", ovr_n - o0, 1);
    tick(1);
    data_ready = 1'b1;
    tick(1);
    data_ready = 1'b0;
    @(negedge clk);
    check("ovr drain valid", data_valid, 1'b0);
    check("ovr drain data_out", data_out, 8'h11);
    check("ovr drain count", got_n - g0, 1);
    check("ovr drain byte", got[g0], 8'h11);

    // Framing error and BREAK
    data_ready = 1'b1;
    tick(2);
    g0 = got_n; f0 = ferr_n; v0 = vhi_n;
    send_bits(8'hC3, 1'b0);
    tick(40);
    @(negedge clk);
    check("break busy held", busy, 1'b1);
    tick(1);
    rx = 1'b1;
    @(negedge clk);
    check("break busy at release", busy, 1'b1);
    tick(2);
    @(negedge clk);
    check("break busy +2", busy, 1'b1);
    tick(1);
    @(negedge clk);
    check("break busy +3", busy, 1'b0);
    tick(5);
    check("break frame_err", ferr_n - f0, 1);
    check("break no valid", vhi_n - v0, 0);
    send_frame(8'h7E, 1'b1);
    tick(10);
    check("post-break count", got_n - g0, 1);
    check("post-break byte", got[g0], 8'h7E);

    // Glitch rejection
    g0 = got_n; f0 = ferr_n;
    rx = 1'b0;
    tick(2);
    rx = 1'b1;
    tick(3);
    @(negedge clk);
    check("glitch busy t0+2", busy, 1'b1);
    tick(1);
    @(negedge clk);
    check("glitch busy t0+3", busy, 1'b1);
    tick(1);
    @(negedge clk);
    check("glitch idle t0+4", busy, 1'b0);
    tick(100);
    check("glitch no byte", got_n - g0, 0);
    check("glitch no frame_err", ferr_n - f0, 0);

    // Reset mid-frame
    g0 = got_n; f0 = ferr_n;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        tick(44);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
      end
    join
    tick(5);
    send_frame(8'h81, 1'b1);
    tick(10);
    check("midreset count", got_n - g0, 1);
    check("midreset byte", got[g0], 8'h81);
    check("midreset frame_err", ferr_n - f0, 0);

    // Randomized frames against a queue model
    g0 = got_n; f0 = ferr_n; o0 = ovr_n;
    exp_ferr = 0;
    for (int i = 0; i < 24; i++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 4) != 0);
      send_frame(b, ok);
      if (ok) exp_q.push_back(b);
      else exp_ferr++;
      tick($urandom_range(1, 20));
    end
    tick(10);
    check("rand count", got_n - g0, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("rand byte %0d", i), got[g0+i], exp_q[i]);
    end
    check("rand frame_err", ferr_n - f0, exp_ferr);
    check("rand overrun", ovr_n - o0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
